// File: rtl/gctr_cb_sequencer.sv
// GCTR counter-block sequencer: streams inc_S counter blocks derived from J0 over valid/ready.
// Optional `GCTR_CB_J0_EMIT_EN: emit J0 itself ahead of the data blocks, flagged by cb_is_j0.
module gctr_cb_sequencer #(
    parameter int unsigned S          = 32,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] j0,
    input  logic [CNT_WIDTH-1:0]  num_blocks,
    input  logic                  abort,
    input  logic                  cb_ready,
    output logic                  cb_valid,
    output logic [DATA_WIDTH-1:0] cb_data,
    output logic                  cb_last,
`ifdef GCTR_CB_J0_EMIT_EN
    output logic                  cb_is_j0,
`endif
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE, RUN} state_t;

    // Mask form avoids an empty upper slice when S == DATA_WIDTH.
    localparam logic [DATA_WIDTH-1:0] LOW_MASK =
        (S >= DATA_WIDTH) ? '1 : ((DATA_WIDTH'(1) << S) - DATA_WIDTH'(1));

    function automatic logic [DATA_WIDTH-1:0] inc_s(input logic [DATA_WIDTH-1:0] x);
        return (x & ~LOW_MASK) | ((x + DATA_WIDTH'(1)) & LOW_MASK);
    endfunction

    state_t               state;
    logic [CNT_WIDTH-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cb_valid  <= 1'b0;
            cb_data   <= '0;
            cb_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
`ifdef GCTR_CB_J0_EMIT_EN
            cb_is_j0  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
`ifdef GCTR_CB_J0_EMIT_EN
                    remaining <= num_blocks;
                    cb_data   <= j0;
                    cb_is_j0  <= 1'b1;
                    cb_last   <= (num_blocks == '0);
                    cb_valid  <= 1'b1;
                    busy      <= 1'b1;
                    state     <= RUN;
`else
                    if (num_blocks != '0) begin
                        remaining <= num_blocks;
                        cb_data   <= inc_s(j0);
                        cb_last   <= (num_blocks == CNT_WIDTH'(1));
                        cb_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
`endif
                end
            end else begin
                if (abort) begin
                    state     <= IDLE;
                    cb_valid  <= 1'b0;
                    cb_last   <= 1'b0;
                    busy      <= 1'b0;
                    remaining <= '0;
`ifdef GCTR_CB_J0_EMIT_EN
                    cb_is_j0  <= 1'b0;
`endif
                end else if (cb_ready) begin
                    if (cb_last) begin
                        state     <= IDLE;
                        cb_valid  <= 1'b0;
                        cb_last   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remaining <= '0;
`ifdef GCTR_CB_J0_EMIT_EN
                        cb_is_j0  <= 1'b0;
`endif
                    end else begin
                        cb_data <= inc_s(cb_data);
`ifdef GCTR_CB_J0_EMIT_EN
                        // J0 does not consume a data-block count.
                        if (cb_is_j0) begin
                            cb_is_j0 <= 1'b0;
                            cb_last  <= (remaining == CNT_WIDTH'(1));
                        end else begin
                            remaining <= remaining - CNT_WIDTH'(1);
                            cb_last   <= (remaining == CNT_WIDTH'(2));
                        end
`else
                        remaining <= remaining - CNT_WIDTH'(1);
                        cb_last   <= (remaining == CNT_WIDTH'(2));
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gctr_cb_sequencer.sv
// Randomized self-checking bench for gctr_cb_sequencer against an expected-block-list model.
module tb_gctr_cb_sequencer;

    localparam int unsigned DW = 128;
    localparam int unsigned TS = 32;
    localparam int unsigned CW = 32;
`ifdef GCTR_CB_J0_EMIT_EN
    localparam bit J0_EMIT = 1'b1;
`else
    localparam bit J0_EMIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] j0;
    logic [CW-1:0] num_blocks;
    logic          abort;
    logic          cb_ready;
    logic          cb_valid;
    logic [DW-1:0] cb_data;
    logic          cb_last;
    logic          cb_is_j0;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifndef GCTR_CB_J0_EMIT_EN
    assign cb_is_j0 = 1'b0;
`endif

    gctr_cb_sequencer #(.S(TS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .j0(j0), .num_blocks(num_blocks),
        .abort(abort), .cb_ready(cb_ready), .cb_valid(cb_valid), .cb_data(cb_data),
        .cb_last(cb_last),
`ifdef GCTR_CB_J0_EMIT_EN
        .cb_is_j0(cb_is_j0),
`endif
        .busy(busy), .done(done)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // k-th counter block after base: low TS bits advance modulo 2^TS, upper bits fixed.
    function automatic logic [DW-1:0] ctr_block(input logic [DW-1:0] base, input int unsigned k);
        logic [TS-1:0] low;
        low = base[TS-1:0] + TS'(k);
        return {base[DW-1:TS], low};
    endfunction

    task automatic run_seq(input logic [DW-1:0] base, input int unsigned n,
                           input int unsigned ready_pct, input int stall_idx, input int abort_at);
        logic [DW-1:0] exp_q[$];
        int unsigned   idx = 0;
        int unsigned   stall = 0;
        int unsigned   budget = 2000;
        bit            hs;
        for (int unsigned k = (J0_EMIT ? 0 : 1); k <= n; k++) exp_q.push_back(ctr_block(base, k));

        check_eq("idle_busy", busy, 1'b0);
        start = 1'b1; j0 = base; num_blocks = CW'(n);
        abort = 1'($urandom_range(1)); cb_ready = 1'($urandom_range(1));
        @(negedge clk);
        start = 1'b0; abort = 1'b0;

        if (exp_q.size() == 0) begin
            check_eq("zero_done", done, 1'b1);
            check_eq("zero_valid", cb_valid, 1'b0);
            check_eq("zero_busy", busy, 1'b0);
            return;
        end

        while (idx < exp_q.size() && budget != 0) begin
            check_eq("run_valid", cb_valid, 1'b1);
            check_eq("run_busy", busy, 1'b1);
            check_eq("run_done", done, 1'b0);
            check_eq("run_data", cb_data, exp_q[idx]);
            check_eq("run_last", cb_last, (idx == exp_q.size() - 1));
            check_eq("run_is_j0", cb_is_j0, (J0_EMIT && idx == 0));
            if (int'(idx) == abort_at) begin
                abort = 1'b1; cb_ready = 1'($urandom_range(1)); start = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                check_eq("abort_valid", cb_valid, 1'b0);
                check_eq("abort_busy", busy, 1'b0);
                check_eq("abort_last", cb_last, 1'b0);
                check_eq("abort_done", done, 1'b0);
                @(negedge clk);
                check_eq("abort_nodone", done, 1'b0);
                check_eq("abort_idle", busy, 1'b0);
                return;
            end
            if (int'(idx) == stall_idx && stall < 3) begin
                cb_ready = 1'b0;
                stall++;
            end else begin
                cb_ready = ($urandom_range(99) < ready_pct);
            end
            // Starts while busy must be ignored.
            start = ($urandom_range(3) == 0);
            j0 = {$urandom, $urandom, $urandom, $urandom};
            num_blocks = CW'($urandom_range(9));
            hs = cb_ready;
            @(negedge clk);
            budget--;
            if (hs) idx++;
        end
        start = 1'b0;
        check_eq("seq_budget", (budget != 0), 1'b1);
        check_eq("end_done", done, 1'b1);
        check_eq("end_valid", cb_valid, 1'b0);
        check_eq("end_last", cb_last, 1'b0);
        check_eq("end_busy", busy, 1'b0);
        check_eq("end_is_j0", cb_is_j0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] base;
        logic [TS-1:0] low;
        rst = 1'b1; start = 1'b0; j0 = '0; num_blocks = '0; abort = 1'b0; cb_ready = 1'b0;
        #1;
        check_eq("rst_valid", cb_valid, 1'b0);
        check_eq("rst_data", cb_data, '0);
        check_eq("rst_last", cb_last, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_is_j0", cb_is_j0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_seq({96'hCAFEBABE_DEADBEEF_01234567, 32'h00000001}, 3, 100, -1, -1);
        run_seq({96'h0F0E0D0C_0B0A0908_07060504, 32'hFFFFFFFE}, 3, 100, -1, -1);
        run_seq({96'h11112222_33334444_55556666, 32'h00000010}, 3, 100, 1, -1);
        run_seq({96'hA5A5A5A5_5A5A5A5A_A5A5A5A5, 32'h12345678}, 0, 100, -1, -1);
        run_seq({96'h01020304_05060708_090A0B0C, 32'h00000020}, 5, 100, -1, 1);
        run_seq({96'h01020304_05060708_090A0B0C, 32'h00000020}, 2, 100, -1, -1);
        run_seq({96'hCAFEBABE_DEADBEEF_01234567, 32'h00000001}, 2, 100, -1, -1);

        start = 1'b1; j0 = {$urandom, $urandom, $urandom, $urandom}; num_blocks = 5; cb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", cb_valid, 1'b0);
        check_eq("arst_data", cb_data, '0);
        check_eq("arst_last", cb_last, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_is_j0", cb_is_j0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("arst_nodone", done, 1'b0);

        for (int t = 0; t < 30; t++) begin
            low = ($urandom_range(1) == 1) ? (32'hFFFFFFFF - 32'($urandom_range(5))) : $urandom;
            base = {$urandom, $urandom, $urandom, low};
            run_seq(base, $urandom_range(8), $urandom_range(100, 30),
                    ($urandom_range(2) == 0) ? int'($urandom_range(3)) : -1,
                    ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
